rtc_timer: RTL and testbench

Free-running 64-bit real-time counter with a programmable clock prescaler, a memory-mapped register port and an optional compare/interrupt unit. Its `wall_time` output drives the `wall_time` input of the CSR file, which serves `time`/`timeh` reads from it. Software reads and writes the counter, and the compare register, over a simple single-outstanding valid/ready register bus.

---
 rtl/rtc_timer.sv | 151 +++++++++++++++
 tb/tb_rtc_timer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_timer.sv
// rtc_timer: free-running 64-bit mtime counter with clock prescaler and a valid/ready register port.
// Defining RTC_TIMER_CMP_EN adds the mtimecmp registers, the comparator and timer_irq.
module rtc_timer #(
   parameter int unsigned CLK_DIV = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bus_valid,
   input  logic        bus_we,
   input  logic [3:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic        bus_ready,
   output logic [31:0] bus_rdata,
   output logic        bus_err,
   output logic [63:0] wall_time,
   output logic        timer_irq
);

   localparam int unsigned PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RESP = 1'b1;

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [63:0]        mtime_q, mtime_d;
   logic [31:0]        hi_shadow_q, hi_shadow_d;
   logic [0:0]         state_q, state_d;
   logic               bus_ready_q, bus_ready_d;
   logic [31:0]        bus_rdata_q, bus_rdata_d;
   logic               bus_err_q, bus_err_d;
   logic               tick;
   logic               accept;
`ifdef RTC_TIMER_CMP_EN
   logic [63:0]        mtimecmp_q, mtimecmp_d;
   logic               timer_irq_q, timer_irq_d;
`endif

   // Prescaler, mtime update and bus access decode.
   always_comb begin
      presc_d     = presc_q;
      tick        = 1'b0;
      mtime_d     = mtime_q;
      hi_shadow_d = hi_shadow_q;
      state_d     = state_q;
      accept      = 1'b0;
      bus_ready_d = 1'b0;
      bus_rdata_d = '0;
      bus_err_d   = 1'b0;
`ifdef RTC_TIMER_CMP_EN
      mtimecmp_d  = mtimecmp_q;
      timer_irq_d = (mtime_q >= mtimecmp_q);
`endif

      if (presc_q == PRESC_MAX) begin
         presc_d = '0;
         tick    = 1'b1;
      end else begin
         presc_d = presc_q + PRESC_W'(1);
      end
      mtime_d = mtime_q + 64'(tick);

      case (state_q)
         S_IDLE: begin
            if (bus_valid) begin
               state_d = S_RESP;
               accept  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A write to mtime overrides a same-edge tick and never carries between halves.
      if (accept) begin
         bus_ready_d = 1'b1;
         if (bus_addr[1:0] != 2'b00) begin
            bus_err_d = 1'b1;
         end else begin
            case (bus_addr[3:2])
               2'd0: begin
                  if (bus_we) begin
                     mtime_d = {mtime_q[63:32], bus_wdata};
                  end else begin
                     bus_rdata_d = mtime_q[31:0];
                     hi_shadow_d = mtime_q[63:32];
                  end
               end
               2'd1: begin
                  if (bus_we) begin
                     mtime_d = {bus_wdata, mtime_q[31:0]};
                  end else begin
                     bus_rdata_d = hi_shadow_q;
                  end
               end
`ifdef RTC_TIMER_CMP_EN
               2'd2: begin
                  if (bus_we) mtimecmp_d = {mtimecmp_q[63:32], bus_wdata};
                  else        bus_rdata_d = mtimecmp_q[31:0];
               end
               2'd3: begin
                  if (bus_we) mtimecmp_d = {bus_wdata, mtimecmp_q[31:0]};
                  else        bus_rdata_d = mtimecmp_q[63:32];
               end
`else
               2'd2:    bus_err_d = 1'b1;
               2'd3:    bus_err_d = 1'b1;
`endif
               default: bus_err_d = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q     <= '0;
         mtime_q     <= '0;
         hi_shadow_q <= '0;
         state_q     <= S_IDLE;
         bus_ready_q <= 1'b0;
         bus_rdata_q <= '0;
         bus_err_q   <= 1'b0;
`ifdef RTC_TIMER_CMP_EN
         mtimecmp_q  <= '1;
         timer_irq_q <= 1'b0;
`endif
      end else begin
         presc_q     <= presc_d;
         mtime_q     <= mtime_d;
         hi_shadow_q <= hi_shadow_d;
         state_q     <= state_d;
         bus_ready_q <= bus_ready_d;
         bus_rdata_q <= bus_rdata_d;
         bus_err_q   <= bus_err_d;
`ifdef RTC_TIMER_CMP_EN
         mtimecmp_q  <= mtimecmp_d;
         timer_irq_q <= timer_irq_d;
`endif
      end
   end

   assign bus_ready = bus_ready_q;
   assign bus_rdata = bus_rdata_q;
   assign bus_err   = bus_err_q;
   assign wall_time = mtime_q;
`ifdef RTC_TIMER_CMP_EN
   assign timer_irq = timer_irq_q;
`else
   assign timer_irq = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_timer.sv
// Bench for rtc_timer: directed and randomized register traffic against a behavioural model.
// Covers both builds; compare-unit checks follow RTC_TIMER_CMP_EN.
module tb_rtc_timer;

   localparam int unsigned TB_DIV = 4;
`ifdef RTC_TIMER_CMP_EN
   localparam bit CMP_EN = 1'b1;
`else
   localparam bit CMP_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        bus_valid;
   logic        bus_we;
   logic [3:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ready;
   logic [31:0] bus_rdata;
   logic        bus_err;
   logic [63:0] wall_time;
   logic        timer_irq;

   logic        d1_ready;
   logic [31:0] d1_rdata;
   logic        d1_err;
   logic [63:0] d1_wall;
   logic        d1_irq;

   rtc_timer #(.CLK_DIV(TB_DIV)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
      .bus_rdata(bus_rdata), .bus_err(bus_err), .wall_time(wall_time),
      .timer_irq(timer_irq)
   );

   // Idle divide-by-one instance: mtime must equal the number of edges since reset.
   rtc_timer #(.CLK_DIV(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus_valid(1'b0), .bus_we(1'b0),
      .bus_addr(4'h0), .bus_wdata(32'h0), .bus_ready(d1_ready),
      .bus_rdata(d1_rdata), .bus_err(d1_err), .wall_time(d1_wall),
      .timer_irq(d1_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   bit          chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: edges since reset drive the ticks; a single response may be pending.
   logic [63:0] m_time   = '0;
   logic [63:0] m_cmp    = '1;
   logic [31:0] m_shadow = '0;
   int unsigned m_edges  = 0;
   logic        e_ready  = 1'b0;
   logic        e_err    = 1'b0;
   logic        e_irq    = 1'b0;
   logic [31:0] e_rdata  = '0;
   logic [63:0] pre_time, pre_cmp;
   logic        m_accept;

   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         m_time = '0; m_cmp = '1; m_shadow = '0; m_edges = 0;
         e_ready = 1'b0; e_err = 1'b0; e_irq = 1'b0; e_rdata = '0;
      end else begin
         pre_time = m_time;
         pre_cmp  = m_cmp;
         m_edges++;
         e_irq = CMP_EN && (pre_time >= pre_cmp);
         if ((m_edges % TB_DIV) == 0) m_time = pre_time + 64'd1;
         m_accept = bus_valid && !e_ready;
         e_ready  = m_accept;
         e_err    = 1'b0;
         e_rdata  = '0;
         if (m_accept) begin
            if (bus_addr[1:0] != 2'b00 || (bus_addr[3] && !CMP_EN)) begin
               e_err = 1'b1;
            end else if (bus_we) begin
               case (bus_addr[3:2])
                  2'd0: m_time = {pre_time[63:32], bus_wdata};
                  2'd1: m_time = {bus_wdata, pre_time[31:0]};
                  2'd2: m_cmp  = {pre_cmp[63:32], bus_wdata};
                  default: m_cmp = {bus_wdata, pre_cmp[31:0]};
               endcase
            end else begin
               case (bus_addr[3:2])
                  2'd0: begin e_rdata = pre_time[31:0]; m_shadow = pre_time[63:32]; end
                  2'd1: e_rdata = m_shadow;
                  2'd2: e_rdata = pre_cmp[31:0];
                  default: e_rdata = pre_cmp[63:32];
               endcase
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("bus_ready", 64'(bus_ready), 64'(e_ready));
         chk("bus_rdata", 64'(bus_rdata), 64'(e_rdata));
         chk("bus_err",   64'(bus_err),   64'(e_err));
         chk("wall_time", wall_time,      m_time);
         chk("timer_irq", 64'(timer_irq), 64'(e_irq));
         chk("div1_wall", d1_wall,        64'(m_edges));
         chk("div1_idle", {d1_rdata, 29'd0, d1_ready, d1_err, d1_irq}, 64'd0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   logic [31:0] rd;
   logic        er;
   int          cnt;

   task automatic access(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                         output logic [31:0] rdo, output logic erro);
      bus_valid = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
      rdo = '0; erro = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus_ready) begin
            rdo = bus_rdata; erro = bus_err;
            bus_valid = 1'b0;
            return;
         end
      end
      bus_valid = 1'b0;
      n_cmp++; n_bad++;
      $display("FAIL access_timeout: got no bus_ready, expected one within 4 cycles (addr %h)", addr);
   endtask

   initial begin
      rst_n = 1'b0; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_wall", wall_time, 64'd0);
      chk("rst_irq_ready", {62'd0, timer_irq, bus_ready}, 64'd0);

      // Prescaler from reset release.
      rst_n = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (i == 4)   chk("presc_4",   wall_time, 64'd1);
         if (i == 8)   chk("presc_8",   wall_time, 64'd2);
         if (i == 100) chk("presc_100", wall_time, 64'd25);
      end
      chk("div1_100", d1_wall, 64'd100);

      // Write on a tick edge: the write wins, next tick a full period later.
      while ((m_edges % TB_DIV) != TB_DIV - 1) @(negedge clk);
      access(1'b1, 4'h0, 32'h0000_0100, rd, er);
      chk("collide_val", wall_time, 64'h100);
      repeat (TB_DIV - 1) @(negedge clk);
      chk("collide_hold", wall_time, 64'h100);
      @(negedge clk);
      chk("collide_next", wall_time, 64'h101);

      // Wrap from all ones, then coherent read of the high half.
      access(1'b1, 4'h4, 32'hFFFF_FFFF, rd, er);
      access(1'b1, 4'h0, 32'hFFFF_FFFF, rd, er);
      for (int i = 0; i < 8 && wall_time == 64'hFFFF_FFFF_FFFF_FFFF; i++) @(negedge clk);
      chk("wrap_zero", wall_time, 64'd0);
      access(1'b0, 4'h0, 32'h0, rd, er);
      access(1'b0, 4'h4, 32'h0, rd, er);
      chk("wrap_hi_shadow", 64'(rd), 64'd0);

`ifdef RTC_TIMER_CMP_EN
      access(1'b1, 4'h8, 32'h20, rd, er);
      access(1'b1, 4'hC, 32'h0, rd, er);
      access(1'b1, 4'h4, 32'h0, rd, er);
      access(1'b1, 4'h0, 32'h0, rd, er);
      for (int i = 0; i < 200 && wall_time != 64'h20; i++) @(negedge clk);
      chk("cmp_reach", wall_time, 64'h20);
      chk("irq_before", 64'(timer_irq), 64'd0);
      @(negedge clk);
      chk("irq_rise", 64'(timer_irq), 64'd1);
      access(1'b1, 4'hC, 32'h1, rd, er);
      @(negedge clk);
      chk("irq_clear", 64'(timer_irq), 64'd0);
`else
      access(1'b0, 4'h8, 32'h0, rd, er);
      chk("nocmp_err", 64'(er), 64'd1);
      chk("nocmp_rdata", 64'(rd), 64'd0);
`endif

      // Misaligned access.
      access(1'b0, 4'h2, 32'h0, rd, er);
      chk("misalign_err", 64'(er), 64'd1);
      chk("misalign_rdata", 64'(rd), 64'd0);
      @(negedge clk);
      chk("misalign_pulse", 64'(bus_ready), 64'd0);

      // Valid held high: one accept every second cycle.
      bus_valid = 1'b1; bus_we = 1'b0; bus_addr = 4'h0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus_ready) cnt++;
      end
      bus_valid = 1'b0;
      chk("held_valid_accepts", 64'(cnt), 64'd4);

      // Reset during the response cycle.
      @(negedge clk);
      bus_valid = 1'b1; bus_we = 1'b0; bus_addr = 4'h0;
      @(negedge clk);
      chk("pre_reset_ready", 64'(bus_ready), 64'd1);
      rst_n = 1'b0; bus_valid = 1'b0;
      @(negedge clk);
      chk("reset_resp_dropped", {bus_rdata, 29'd0, bus_ready, bus_err, timer_irq}, 64'd0);
      chk("reset_resp_wall", wall_time, 64'd0);
      rst_n = 1'b1;

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 300; n++) begin
         logic [3:0]  a;
         logic [31:0] w;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         if ($urandom_range(0, 59) == 0) begin
            rst_n = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            rst_n = 1'b1;
         end
         a = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
         case ($urandom_range(0, 3))
            0:       w = 32'($urandom_range(0, 64));
            1:       w = 32'h0;
            2:       w = 32'hFFFF_FFFF;
            default: w = $urandom;
         endcase
         access(1'($urandom_range(0, 1)), a, w, rd, er);
      end

      repeat (4) @(negedge clk);
      chk_en = 1'b0;
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
